// File: rtl/lsu_ctrl.sv
// Load/store unit acting as data-memory initiator: one request at a time,
// aligned accesses go out whole, misaligned half/word accesses become byte sequences.
module lsu_ctrl #(
  parameter int SPLIT_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_SPLIT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        misaligned;
  logic [31:0] merged;
  logic [31:0] wdata_shift;
  logic [1:0]  last_k;

  always_comb begin
    misaligned  = ((req_size == SZ_HALF) && req_addr[0]) ||
                  ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    last_k      = (size_q == SZ_HALF) ? 2'd1 : 2'd3;
    wdata_shift = wdata_q >> {k_q, 3'b000};
    // Result with the byte arriving this cycle dropped into lane k.
    merged = result_q;
    merged[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    result_d     = result_q;
    resp_rdata_d = resp_rdata_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = 2'b00;
    mem_unsigned = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          uns_d    = req_unsigned;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = 1'b0;
          result_d = 32'd0;
          k_d      = 2'd0;
          if ((req_size == SZ_ILL) || (misaligned && (SPLIT_EN == 0))) begin
            state_d      = S_DONE;
            err_d        = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (misaligned) begin
            state_d = S_SPLIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        mem_addr     = addr_q;
        mem_size     = size_q;
        mem_unsigned = uns_q;
        mem_wdata    = wdata_q;
        mem_read     = !we_q;
        mem_write    = we_q;
        resp_rdata_d = we_q ? 32'd0 : mem_rdata;
        state_d      = S_DONE;
      end
      S_SPLIT: begin
        mem_addr     = addr_q + {30'd0, k_q};
        mem_size     = 2'b00;
        mem_unsigned = 1'b1;
        mem_wdata    = {24'd0, wdata_shift[7:0]};
        mem_read     = !we_q;
        mem_write    = we_q;
        result_d     = merged;
        if (k_q == last_k) begin
          state_d = S_DONE;
          if (we_q) begin
            resp_rdata_d = 32'd0;
          end else if (size_q == SZ_HALF) begin
            resp_rdata_d = uns_q ? {16'd0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
          end else begin
            resp_rdata_d = merged;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      default: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = S_IDLE;
      end
    endcase
  end

  assign resp_rdata = resp_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= 2'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
      result_q     <= 32'd0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      result_q     <= result_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: byte-addressed memory model plus hand-computed expectations.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid2;
  logic        req_ready, req_ready2;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_valid2;
  logic [31:0] resp_rdata, resp_rdata2;
  logic        resp_err, resp_err2;
  logic [31:0] mem_addr, mem_addr2;
  logic [31:0] mem_wdata, mem_wdata2;
  logic [31:0] mem_rdata;
  logic        mem_read, mem_read2, mem_write, mem_write2;
  logic [1:0]  mem_size, mem_size2;
  logic        mem_unsigned, mem_unsigned2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:4095];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_we[$];
  logic [1:0]  log_size[$];
  int          strobes2 = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.SPLIT_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned)
  );

  lsu_ctrl #(.SPLIT_EN(0)) dut_nosplit (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid2),
    .resp_rdata(resp_rdata2), .resp_err(resp_err2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(32'd0), .mem_read(mem_read2),
    .mem_write(mem_write2), .mem_size(mem_size2), .mem_unsigned(mem_unsigned2)
  );

  // Memory model: combinational read with size/extension, commit on posedge.
  always_comb begin
    logic [11:0] a;
    a = mem_addr[11:0];
    mem_rdata = 32'd0;
    case (mem_size)
      2'b00: mem_rdata = mem_unsigned ? {24'd0, mem[a]} : {{24{mem[a][7]}}, mem[a]};
      2'b01: mem_rdata = mem_unsigned ? {16'd0, mem[a+12'd1], mem[a]}
                                      : {{16{mem[a+12'd1][7]}}, mem[a+12'd1], mem[a]};
      default: mem_rdata = {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      log_addr.push_back(mem_addr);
      log_wdata.push_back(mem_wdata);
      log_we.push_back(mem_write);
      log_size.push_back(mem_size);
      check("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
    end
    if (mem_write) begin
      mem[mem_addr[11:0]] <= mem_wdata[7:0];
      if (mem_size != 2'b00) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
        mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
      end
    end
    if (mem_read2 || mem_write2) strobes2 <= strobes2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    log_addr.delete(); log_wdata.delete(); log_we.delete(); log_size.delete();
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'd0; er = 1'b0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err;
        break;
      end
    end
    if (lat >= 12) check("resp_timeout", {31'd0, resp_valid}, 32'd1);
    $display("txn we=%0b size=%0d uns=%0b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d accesses=%0d",
             we, sz, uns, a, wd, rd, er, lat, log_addr.size());
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    // 1: aligned store then load
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h44332211, rd, er, lat);
    check("t1_st_writes", log_addr.size(), 32'd1);
    check("t1_st_size", {30'd0, log_size[0]}, 32'd2);
    check("t1_st_wdata", log_wdata[0], 32'h44332211);
    check("t1_st_rdata", rd, 32'd0);
    check("t1_st_lat", lat, 32'd2);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
    check("t1_ld_rdata", rd, 32'h44332211);
    check("t1_ld_lat", lat, 32'd2);
    check("t1_ld_err", {31'd0, er}, 32'd0);

    // 2: misaligned word load
    do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'h88776655, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, rd, er, lat);
    check("t2_rdata", rd, 32'h55443322);
    check("t2_lat", lat, 32'd5);
    check("t2_reads", log_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check("t2_addr", log_addr[i], 32'h101 + i);
      check("t2_size", {30'd0, log_size[i]}, 32'd0);
    end

    // 3: misaligned half loads, signed and unsigned; aligned half passes through
    do_req(1'b1, 2'b10, 1'b0, 32'h108, 32'h000000AA, rd, er, lat);
    do_req(1'b0, 2'b01, 1'b0, 32'h107, 32'h0, rd, er, lat);
    check("t3_signed", rd, 32'hFFFFAA88);
    check("t3_signed_reads", log_addr.size(), 32'd2);
    check("t3_lat", lat, 32'd3);
    do_req(1'b0, 2'b01, 1'b1, 32'h107, 32'h0, rd, er, lat);
    check("t3_unsigned", rd, 32'h0000AA88);
    check("t3_unsigned_reads", log_addr.size(), 32'd2);
    do_req(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, rd, er, lat);
    check("t3_aligned_half", rd, 32'hFFFF8877);
    do_req(1'b0, 2'b00, 1'b1, 32'h107, 32'h0, rd, er, lat);
    check("t3_byte_uns", rd, 32'h00000088);

    // 4: misaligned word store crossing 0x200
    do_req(1'b1, 2'b10, 1'b0, 32'h1FE, 32'hDEADBEEF, rd, er, lat);
    check("t4_writes", log_addr.size(), 32'd4);
    check("t4_lat", lat, 32'd5);
    if (log_addr.size() == 4) begin
      check("t4_a0", log_addr[0], 32'h1FE); check("t4_d0", log_wdata[0], 32'hEF);
      check("t4_a1", log_addr[1], 32'h1FF); check("t4_d1", log_wdata[1], 32'hBE);
      check("t4_a2", log_addr[2], 32'h200); check("t4_d2", log_wdata[2], 32'hAD);
      check("t4_a3", log_addr[3], 32'h201); check("t4_d3", log_wdata[3], 32'hDE);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, rd, er, lat);
    check("t4_ld_1fc", rd, 32'hBEEF0000);
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, er, lat);
    check("t4_ld_200", rd, 32'h0000DEAD);

    // 5: illegal size, and misaligned with splitting disabled
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, er, lat);
    check("t5_err", {31'd0, er}, 32'd1);
    check("t5_rdata", rd, 32'd0);
    check("t5_lat", lat, 32'd1);
    check("t5_strobes", log_addr.size(), 32'd0);
    @(negedge clk);
    check("t5b_ready", {31'd0, req_ready2}, 32'd1);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h102;
    req_valid2 = 1'b1;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    @(negedge clk);
    check("t5b_valid", {31'd0, resp_valid2}, 32'd1);
    check("t5b_err", {31'd0, resp_err2}, 32'd1);
    check("t5b_rdata", resp_rdata2, 32'd0);
    check("t5b_strobes", strobes2, 32'd0);
    $display("txn nosplit load word addr=00000102 -> err=%0b rdata=%08h", resp_err2, resp_rdata2);

    // 6: reset mid split store, after two bytes have committed
    @(negedge clk);
    log_addr.delete(); log_wdata.delete(); log_we.delete(); log_size.delete();
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h301; req_wdata = 32'hCAFEBABE;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready", {31'd0, req_ready}, 32'd1);
    check("t6_no_resp", {31'd0, resp_valid}, 32'd0);
    check("t6_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    rst = 1'b0;
    check("t6_writes", log_addr.size(), 32'd2);
    $display("txn split store interrupted by reset, writes=%0d", log_addr.size());
    do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, rd, er, lat);
    check("t6_ld_300", rd, 32'h00BABE00);

    // address wrap across 0xFFFFFFFF
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, rd, er, lat);
    check("wrap_reads", log_addr.size(), 32'd4);
    if (log_addr.size() == 4) begin
      check("wrap_a0", log_addr[0], 32'hFFFFFFFF);
      check("wrap_a1", log_addr[1], 32'h00000000);
      check("wrap_a2", log_addr[2], 32'h00000001);
      check("wrap_a3", log_addr[3], 32'h00000002);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
